// File: rtl/reg_transfer_unit.sv
// reg_transfer_unit: eight-register bank with MOV/SWAP/LOAD/CLR transfer sequencer driving an external bus mux
module reg_transfer_unit #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [2:0]       src_sel,
  input  logic [2:0]       dst_sel,
  input  logic [WIDTH-1:0] ext_data,
  input  logic [WIDTH-1:0] Bus,
  output logic [2:0]       Src,
  output logic [WIDTH-1:0] reg_Out1,
  output logic [WIDTH-1:0] reg_Out2,
  output logic [WIDTH-1:0] reg_Out3,
  output logic [WIDTH-1:0] reg_Out4,
  output logic [WIDTH-1:0] reg_Out5,
  output logic [WIDTH-1:0] reg_Out6,
  output logic [WIDTH-1:0] reg_Out7,
  output logic [WIDTH-1:0] reg_Out8,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, MOVE, SWAP1, SWAP2, SWAP3, EXEC, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] r [8];
  logic [WIDTH-1:0] tmp, data_q, wd;
  logic [1:0] op_q;
  logic [2:0] src_q, dst_q, src_nx, wa;
  logic we;
  always_comb begin
    state_nx = state;
    src_nx = 3'd0;
    we = 1'b0;
    wa = dst_q;
    wd = Bus;
    case (state)
      IDLE: if (start) begin
        state_nx = op == 2'b00 ? MOVE : op == 2'b01 ? SWAP1 : EXEC;
        src_nx = op[1] ? 3'd0 : src_sel;
      end
      MOVE: begin
        we = 1'b1;
        state_nx = DONE;
      end
      SWAP1: begin
        src_nx = dst_q;
        state_nx = SWAP2;
      end
      SWAP2: begin
        we = 1'b1;
        wa = src_q;
        state_nx = SWAP3;
      end
      SWAP3: begin
        we = 1'b1;
        wd = tmp;
        state_nx = DONE;
      end
      EXEC: begin
        we = 1'b1;
        wd = op_q == 2'b10 ? data_q : '0;
        state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      Src <= 3'd0;
      tmp <= RESET_VAL;
      data_q <= RESET_VAL;
      op_q <= 2'b00;
      src_q <= 3'd0;
      dst_q <= 3'd0;
      for (int i = 0; i < 8; i++) r[i] <= RESET_VAL;
    end else begin
      state <= state_nx;
      Src <= src_nx;
      if (state == IDLE && start) begin
        op_q <= op;
        src_q <= src_sel;
        dst_q <= dst_sel;
        data_q <= ext_data;
      end
      if (state == SWAP1) tmp <= Bus;
      if (we) r[wa] <= wd;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign reg_Out1 = r[0];
  assign reg_Out2 = r[1];
  assign reg_Out3 = r[2];
  assign reg_Out4 = r[3];
  assign reg_Out5 = r[4];
  assign reg_Out6 = r[5];
  assign reg_Out7 = r[6];
  assign reg_Out8 = r[7];
endmodule

// File: tb/tb_reg_transfer_unit.sv
// tb_reg_transfer_unit: directed command table plus hand sequences for hold-off and async reset
module tb_reg_transfer_unit;
  logic clk = 0, rst = 1, start = 0;
  logic [1:0] op = 0;
  logic [2:0] src_sel = 0, dst_sel = 0, Src;
  logic [15:0] ext_data = 0, Bus;
  logic [15:0] q [8];
  logic busy, done;
  logic [15:0] exp_r [8];
  int errors = 0, checks = 0;
  typedef struct {
    logic [1:0] op;
    logic [2:0] s, d;
    logic [15:0] data;
    logic [2:0] ia;
    logic [15:0] va;
    logic [2:0] ib;
    logic [15:0] vb;
  } vec_t;
  vec_t v [12];
  always #5 clk = ~clk;
  assign Bus = q[Src];
  reg_transfer_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_sel(src_sel), .dst_sel(dst_sel),
    .ext_data(ext_data), .Bus(Bus), .Src(Src),
    .reg_Out1(q[0]), .reg_Out2(q[1]), .reg_Out3(q[2]), .reg_Out4(q[3]),
    .reg_Out5(q[4]), .reg_Out6(q[5]), .reg_Out7(q[6]), .reg_Out8(q[7]),
    .busy(busy), .done(done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask
  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s reg_Out%0d", tag, i + 1), q[i], exp_r[i]);
  endtask
  task automatic run_cmd(input vec_t c, input int idx);
    int n;
    logic [2:0] s0, s1;
    @(negedge clk);
    start = 1; op = c.op; src_sel = c.s; dst_sel = c.d; ext_data = c.data;
    @(posedge clk); #1;
    start = 0; op = ~c.op; src_sel = ~c.s; dst_sel = ~c.d; ext_data = ~c.data;
    n = 0; s0 = Src; s1 = 0;
    while (!done && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) s1 = Src;
    end
    chk($sformatf("v%0d latency", idx), n, c.op == 2'b01 ? 3 : 1);
    chk($sformatf("v%0d src first", idx), s0, c.op[1] ? 3'd0 : c.s);
    if (c.op == 2'b01) chk($sformatf("v%0d src second", idx), s1, c.d);
    @(posedge clk); #1;
    chk($sformatf("v%0d done low", idx), done, 0);
    chk($sformatf("v%0d busy low", idx), busy, 0);
    exp_r[c.ia] = c.va;
    exp_r[c.ib] = c.vb;
    chk_regs($sformatf("v%0d", idx));
  endtask
  initial begin
    v[0]  = '{2'b10, 3'd0, 3'd3, 16'hA5A5, 3'd3, 16'hA5A5, 3'd3, 16'hA5A5};
    v[1]  = '{2'b00, 3'd3, 3'd7, 16'h0000, 3'd7, 16'hA5A5, 3'd7, 16'hA5A5};
    v[2]  = '{2'b10, 3'd0, 3'd1, 16'h1234, 3'd1, 16'h1234, 3'd1, 16'h1234};
    v[3]  = '{2'b10, 3'd0, 3'd6, 16'hBEEF, 3'd6, 16'hBEEF, 3'd6, 16'hBEEF};
    v[4]  = '{2'b01, 3'd1, 3'd6, 16'h0000, 3'd1, 16'hBEEF, 3'd6, 16'h1234};
    v[5]  = '{2'b10, 3'd0, 3'd5, 16'h00FF, 3'd5, 16'h00FF, 3'd5, 16'h00FF};
    v[6]  = '{2'b01, 3'd5, 3'd5, 16'h0000, 3'd5, 16'h00FF, 3'd5, 16'h00FF};
    v[7]  = '{2'b10, 3'd0, 3'd0, 16'hFFFF, 3'd0, 16'hFFFF, 3'd0, 16'hFFFF};
    v[8]  = '{2'b11, 3'd0, 3'd0, 16'hFFFF, 3'd0, 16'h0000, 3'd0, 16'h0000};
    v[9]  = '{2'b00, 3'd7, 3'd0, 16'h0000, 3'd0, 16'hA5A5, 3'd0, 16'hA5A5};
    v[10] = '{2'b00, 3'd6, 3'd6, 16'h0000, 3'd6, 16'h1234, 3'd6, 16'h1234};
    v[11] = '{2'b10, 3'd0, 3'd7, 16'h8001, 3'd7, 16'h8001, 3'd7, 16'h8001};
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    #1;
    chk_regs("reset");
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset Src", Src, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 12; i++) run_cmd(v[i], i);
    // start held across a LOAD with a different op queued behind it
    @(negedge clk);
    start = 1; op = 2'b10; src_sel = 0; dst_sel = 3'd2; ext_data = 16'h1111;
    @(posedge clk); #1;
    op = 2'b11; dst_sel = 3'd3; ext_data = 16'h7777;
    @(posedge clk); #1;
    chk("hold done first", done, 1);
    chk("hold r3 first", q[2], 16'h1111);
    chk("hold r4 untouched", q[3], 16'hA5A5);
    @(posedge clk); #1;
    chk("hold idle gap", busy, 0);
    @(posedge clk); #1;
    start = 0;
    chk("hold second busy", busy, 1);
    @(posedge clk); #1;
    chk("hold done second", done, 1);
    chk("hold r4 cleared", q[3], 16'h0000);
    chk("hold r3 kept", q[2], 16'h1111);
    @(posedge clk); #1;
    chk("hold back idle", busy, 0);
    // async reset in SWAP2, checked before any further edge
    @(negedge clk);
    start = 1; op = 2'b01; src_sel = 3'd0; dst_sel = 3'd1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #2;
    rst = 1;
    #1;
    for (int i = 0; i < 8; i++) exp_r[i] = 16'h0000;
    chk_regs("midswap rst");
    chk("midswap busy", busy, 0);
    chk("midswap done", done, 0);
    chk("midswap Src", Src, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort done c%0d", i), done, 0);
    end
    chk_regs("post abort");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
